// File: rtl/periph_bus_ctrl.sv
// Peripheral bus controller: decodes a 1 KiB window of 68000 address space into
// four held-strobe peripheral slots, returning DTACK on slot ack or BERR on timeout.
`timescale 1ns/1ps
module periph_bus_ctrl #(
  parameter logic [13:0] BASE    = 14'h3C00,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_as_n,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic        cpu_rw,
  input  logic [23:1] cpu_addr,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  output logic [3:0]  p_sel,
  output logic [7:0]  p_addr,
  output logic [15:0] p_data_write,
  output logic        p_uds,
  output logic        p_lds,
  output logic        p_rw,
  input  logic [63:0] p_data_read,
  input  logic [3:0]  p_ack
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_slot;
  logic [15:0]      r_data_out;
  logic             r_dtack_n;
  logic             r_berr_n;
  logic [3:0]       r_sel;
  logic [7:0]       r_addr;
  logic [15:0]      r_data_write;
  logic             r_uds;
  logic             r_lds;
  logic             r_rw;

  logic             w_start;
  logic             w_ack;
  logic [15:0]      w_rdata;

  assign w_start = ~cpu_as_n & (~cpu_uds_n | ~cpu_lds_n) & (cpu_addr[23:10] == BASE);
  // Only the selected slot's ack can complete a cycle.
  assign w_ack   = |(p_ack & r_sel);
  assign w_rdata = p_data_read[{r_slot, 4'b0000} +: 16];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_DONE;
      r_cnt        <= '0;
      r_slot       <= 2'd0;
      r_data_out   <= 16'h0000;
      r_dtack_n    <= 1'b1;
      r_berr_n     <= 1'b1;
      r_sel        <= 4'b0000;
      r_addr       <= 8'h00;
      r_data_write <= 16'h0000;
      r_uds        <= 1'b0;
      r_lds        <= 1'b0;
      r_rw         <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr       <= {cpu_addr[7:1], 1'b0};
            r_rw         <= cpu_rw;
            r_data_write <= cpu_data_in;
            r_uds        <= ~cpu_uds_n;
            r_lds        <= ~cpu_lds_n;
            r_sel        <= 4'b0001 << cpu_addr[9:8];
            r_slot       <= cpu_addr[9:8];
            r_cnt        <= '0;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Ack takes priority over a timeout reached on the same edge.
          if (w_ack) begin
            if (r_rw) r_data_out <= w_rdata;
            r_sel     <= 4'b0000;
            r_uds     <= 1'b0;
            r_lds     <= 1'b0;
            r_dtack_n <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_cnt + CNT_W'(1) == CNT_LAST) begin
            r_cnt     <= CNT_LAST;
            r_sel     <= 4'b0000;
            r_uds     <= 1'b0;
            r_lds     <= 1'b0;
            r_berr_n  <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (cpu_as_n) begin
            r_dtack_n <= 1'b1;
            r_berr_n  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_DONE;
      endcase
    end
  end

  assign cpu_data_out = r_data_out;
  assign cpu_dtack_n  = r_dtack_n;
  assign cpu_berr_n   = r_berr_n;
  assign p_sel        = r_sel;
  assign p_addr       = r_addr;
  assign p_data_write = r_data_write;
  assign p_uds        = r_uds;
  assign p_lds        = r_lds;
  assign p_rw         = r_rw;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Bench for periph_bus_ctrl: directed and random CPU cycles checked against a
// transaction-level model of when DTACK/BERR fire and what data is returned.
`timescale 1ns/1ps
module tb_periph_bus_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw;
  logic [23:1] cpu_addr;
  logic [15:0] cpu_data_in;
  logic [15:0] cpu_data_out;
  logic        cpu_dtack_n, cpu_berr_n;
  logic [3:0]  p_sel;
  logic [7:0]  p_addr;
  logic [15:0] p_data_write;
  logic        p_uds, p_lds, p_rw;
  logic [63:0] p_data_read;
  logic [3:0]  p_ack;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_dout = 16'h0000;

  periph_bus_ctrl #(.BASE(14'h3C00), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out), .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n),
    .p_sel(p_sel), .p_addr(p_addr), .p_data_write(p_data_write),
    .p_uds(p_uds), .p_lds(p_lds), .p_rw(p_rw),
    .p_data_read(p_data_read), .p_ack(p_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " sel"}, 64'(p_sel), 64'h0);
    chk({tag, " dtack"}, 64'(cpu_dtack_n), 64'h1);
    chk({tag, " berr"}, 64'(cpu_berr_n), 64'h1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_quiet(tag);
    chk({tag, " dout"}, 64'(cpu_data_out), 64'h0);
    chk({tag, " uds"}, 64'(p_uds), 64'h0);
    chk({tag, " lds"}, 64'(p_lds), 64'h0);
    chk({tag, " rw"}, 64'(p_rw), 64'h1);
    chk({tag, " addr"}, 64'(p_addr), 64'h0);
    chk({tag, " wdata"}, 64'(p_data_write), 64'h0);
  endtask

  // One CPU cycle. ack_at = edge after decode at which the selected slot's ack is
  // presented (0 or > TO means never). other = ack bits driven on the other slots.
  task automatic txn(input logic [23:0] baddr, input logic rw, input logic uds,
                     input logic lds, input logic [15:0] wdata, input int ack_at,
                     input logic [3:0] other);
    logic [1:0]  slot;
    logic [3:0]  sel;
    logic [63:0] rd;
    bit          acked;
    int          last;
    slot  = baddr[9:8];
    sel   = 4'b0001 << slot;
    acked = (ack_at >= 1) && (ack_at <= int'(TO));
    last  = acked ? ack_at : int'(TO);
    rd    = {$urandom, $urandom};
    p_data_read = rd;
    cpu_addr    = baddr[23:1];
    cpu_rw      = rw;
    cpu_uds_n   = ~uds;
    cpu_lds_n   = ~lds;
    cpu_data_in = wdata;
    p_ack       = other & ~sel;
    cpu_as_n    = 1'b0;
    step();
    chk("decode sel", 64'(p_sel), 64'(sel));
    chk("decode addr", 64'(p_addr), 64'({baddr[7:1], 1'b0}));
    chk("decode rw", 64'(p_rw), 64'(rw));
    chk("decode wdata", 64'(p_data_write), 64'(wdata));
    chk("decode uds", 64'(p_uds), 64'(uds));
    chk("decode lds", 64'(p_lds), 64'(lds));
    chk("decode dtack", 64'(cpu_dtack_n), 64'h1);
    chk("decode berr", 64'(cpu_berr_n), 64'h1);
    cpu_data_in = 16'($urandom);
    for (int k = 1; k <= last; k++) begin
      p_ack = (other & ~sel) | ((k == ack_at) ? sel : 4'b0000);
      step();
      if (k < last) begin
        chk("access sel held", 64'(p_sel), 64'(sel));
        chk("access wdata held", 64'(p_data_write), 64'(wdata));
        chk("access strobes held", 64'({p_uds, p_lds}), 64'({uds, lds}));
        chk("access dtack", 64'(cpu_dtack_n), 64'h1);
        chk("access berr", 64'(cpu_berr_n), 64'h1);
      end else begin
        if (acked && rw) exp_dout = rd[16*slot +: 16];
        chk("end sel", 64'(p_sel), 64'h0);
        chk("end strobes", 64'({p_uds, p_lds}), 64'h0);
        chk("end dtack", 64'(cpu_dtack_n), acked ? 64'h0 : 64'h1);
        chk("end berr", 64'(cpu_berr_n), acked ? 64'h1 : 64'h0);
        chk("end dout", 64'(cpu_data_out), 64'(exp_dout));
      end
    end
    p_ack = other & ~sel;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("done hold dtack", 64'(cpu_dtack_n), acked ? 64'h0 : 64'h1);
      chk("done hold berr", 64'(cpu_berr_n), acked ? 64'h1 : 64'h0);
      chk("done sel", 64'(p_sel), 64'h0);
    end
    cpu_as_n = 1'b1;
    p_ack    = 4'b0000;
    step();
    chk_quiet("release");
    chk("release dout", 64'(cpu_data_out), 64'(exp_dout));
  endtask

  initial begin
    logic [23:0] a;
    logic [1:0]  lanes;
    reset_n     = 1'b0;
    cpu_as_n    = 1'b0;
    cpu_uds_n   = 1'b0;
    cpu_lds_n   = 1'b0;
    cpu_rw      = 1'b1;
    a           = 24'hF00000;
    cpu_addr    = a[23:1];
    cpu_data_in = 16'h0000;
    p_data_read = 64'h0;
    p_ack       = 4'b0000;
    step();
    step();
    chk_reset_vals("reset");

    // Out of reset with AS still low on a hit: must wait for AS high first.
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_quiet("post-reset AS low");
    end
    cpu_as_n = 1'b1;
    step();
    chk_quiet("arm");

    txn(24'hF00000, 1'b0, 1'b1, 1'b0, 16'hA500, 2, 4'b0000);
    txn(24'hF00206, 1'b1, 1'b1, 1'b1, 16'h0000, 2, 4'b0000);
    chk("read slot2 data", 64'(cpu_data_out), 64'(p_data_read[47:32]));
    txn(24'hF00300, 1'b1, 1'b1, 1'b1, 16'h5555, 0, 4'b0000);
    txn(24'hF00110, 1'b1, 1'b0, 1'b1, 16'h0000, int'(TO), 4'b0001);

    // Window miss: nothing happens however long AS stays low.
    a = 24'h000100;
    cpu_addr  = a[23:1];
    cpu_uds_n = 1'b0;
    cpu_as_n  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      p_ack = 4'($urandom);
      step();
      chk_quiet("miss");
    end
    // Hit with no data strobe is not a cycle.
    a = 24'hF00100;
    cpu_addr  = a[23:1];
    cpu_uds_n = 1'b1;
    cpu_lds_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_quiet("no strobe");
    end
    cpu_as_n = 1'b1;
    p_ack    = 4'b0000;
    step();

    // Reset during ACCESS, then AS held low must not start a new cycle.
    cpu_uds_n = 1'b0;
    cpu_as_n  = 1'b0;
    step();
    chk("pre-reset sel", 64'(p_sel), 64'h2);
    step();
    reset_n = 1'b0;
    step();
    exp_dout = 16'h0000;
    chk_reset_vals("mid reset");
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_quiet("after mid reset");
    end
    cpu_as_n = 1'b1;
    step();
    txn(24'hF00204, 1'b1, 1'b1, 1'b0, 16'h0000, 1, 4'b0000);

    for (int n = 0; n < 40; n++) begin
      lanes = 2'($urandom_range(1, 3));
      a = {14'h3C00, 2'($urandom), 8'($urandom)};
      txn(a, 1'($urandom), lanes[1], lanes[0], 16'($urandom),
          int'($urandom_range(0, TO + 2)), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
